// File: rtl/shift_reg_sp.sv
// rtl/shift_reg_sp.sv - bidirectional serial/parallel shift unit with load handshake, bit counter and done pulse
module shift_reg_sp #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  input  logic             enable_i,
  input  logic             serial_i,
  output logic             serial_o,
  output logic             serial_valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             serial_q, serial_d;
  logic             serial_valid_q, serial_valid_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state logic: accept a load when idle, move one bit per enabled cycle, pulse done for one cycle
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    serial_d       = serial_q;
    serial_valid_d = 1'b0;
    count_d        = count_q;
    case (state_q)
      ST_IDLE: begin
        // a load in the same cycle as enable wins; the enable is simply dropped
        if (load_i) begin
          shreg_d = data_i;
          count_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (enable_i) begin
          if (LSB_FIRST) begin
            serial_d = shreg_q[0];
            shreg_d  = {serial_i, shreg_q[WIDTH-1:1]};
          end else begin
            serial_d = shreg_q[WIDTH-1];
            shreg_d  = {shreg_q[WIDTH-2:0], serial_i};
          end
          serial_valid_d = 1'b1;
          count_d        = count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // register now holds the captured result; count stays at WIDTH until the next load
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset mid-transfer aborts without a done pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      shreg_q        <= '0;
      serial_q       <= 1'b0;
      serial_valid_q <= 1'b0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      serial_q       <= serial_d;
      serial_valid_q <= serial_valid_d;
      count_q        <= count_d;
    end
  end

  // Status outputs are pure decodes of the registered state
  always_comb begin
    ready_o        = (state_q == ST_IDLE);
    busy_o         = (state_q == ST_SHIFT);
    done_o         = (state_q == ST_DONE);
    serial_o       = serial_q;
    serial_valid_o = serial_valid_q;
    data_o         = shreg_q;
    count_o        = count_q;
  end

endmodule

// File: tb/tb_shift_reg_sp.sv
// tb/tb_shift_reg_sp.sv - randomized and directed bench for shift_reg_sp against a bit-queue reference model
module tb_shift_reg_sp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, en, ser;
  logic [15:0] data;

  logic       r0, s0, v0, b0, d0;
  logic [7:0] q0;
  logic [3:0] c0;
  logic       r1, s1, v1, b1, d1;
  logic [7:0] q1;
  logic [3:0] c1;
  logic        r2, s2, v2, b2, d2;
  logic [15:0] q2;
  logic [4:0]  c2;

  shift_reg_sp #(.WIDTH(8), .LSB_FIRST(1'b1)) u_w8_lsb (
    .clk_i(clk), .rst_i(rst), .load_i(load), .data_i(data[7:0]), .ready_o(r0),
    .enable_i(en), .serial_i(ser), .serial_o(s0), .serial_valid_o(v0),
    .data_o(q0), .count_o(c0), .busy_o(b0), .done_o(d0));

  shift_reg_sp #(.WIDTH(8), .LSB_FIRST(1'b0)) u_w8_msb (
    .clk_i(clk), .rst_i(rst), .load_i(load), .data_i(data[7:0]), .ready_o(r1),
    .enable_i(en), .serial_i(ser), .serial_o(s1), .serial_valid_o(v1),
    .data_o(q1), .count_o(c1), .busy_o(b1), .done_o(d1));

  shift_reg_sp #(.WIDTH(16), .LSB_FIRST(1'b1)) u_w16_lsb (
    .clk_i(clk), .rst_i(rst), .load_i(load), .data_i(data), .ready_o(r2),
    .enable_i(en), .serial_i(ser), .serial_o(s2), .serial_valid_o(v2),
    .data_o(q2), .count_o(c2), .busy_o(b2), .done_o(d2));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 shifting, 2 done; k bits moved so far;
  // op is the loaded operand, cap the serial bits captured so far
  int mw[3] = '{8, 8, 16};
  bit ml[3] = '{1'b1, 1'b0, 1'b1};
  int ph[3], op[3], k[3], cap[3], mser[3], msv[3];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_data(int i);
    int mask;
    mask = (1 << mw[i]) - 1;
    if (ml[i]) return ((op[i] >> k[i]) | (cap[i] << (mw[i] - k[i]))) & mask;
    else       return ((op[i] << k[i]) | cap[i]) & mask;
  endfunction

  task automatic model_step();
    int b;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ph[i] = 0; op[i] = 0; k[i] = 0; cap[i] = 0; mser[i] = 0; msv[i] = 0;
      end else begin
        msv[i] = 0;
        if (ph[i] == 0) begin
          if (load) begin
            op[i] = int'(data) & ((1 << mw[i]) - 1);
            k[i] = 0; cap[i] = 0; ph[i] = 1;
          end
        end else if (ph[i] == 1) begin
          if (en) begin
            b = ml[i] ? k[i] : (mw[i] - 1 - k[i]);
            mser[i] = (op[i] >> b) & 1;
            if (ml[i]) cap[i] = cap[i] | (int'(ser) << k[i]);
            else       cap[i] = (cap[i] << 1) | int'(ser);
            k[i]++;
            msv[i] = 1;
            if (k[i] == mw[i]) ph[i] = 2;
          end
        end else begin
          ph[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    int g_r, g_b, g_d, g_s, g_v, g_q, g_c;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin g_r = 32'(r0); g_b = 32'(b0); g_d = 32'(d0); g_s = 32'(s0); g_v = 32'(v0); g_q = 32'(q0); g_c = 32'(c0); end
        1: begin g_r = 32'(r1); g_b = 32'(b1); g_d = 32'(d1); g_s = 32'(s1); g_v = 32'(v1); g_q = 32'(q1); g_c = 32'(c1); end
        default: begin g_r = 32'(r2); g_b = 32'(b2); g_d = 32'(d2); g_s = 32'(s2); g_v = 32'(v2); g_q = 32'(q2); g_c = 32'(c2); end
      endcase
      check_eq($sformatf("u%0d_ready", i), g_r, int'(ph[i] == 0));
      check_eq($sformatf("u%0d_busy", i), g_b, int'(ph[i] == 1));
      check_eq($sformatf("u%0d_done", i), g_d, int'(ph[i] == 2));
      check_eq($sformatf("u%0d_serial", i), g_s, mser[i]);
      check_eq($sformatf("u%0d_svalid", i), g_v, msv[i]);
      check_eq($sformatf("u%0d_data", i), g_q, exp_data(i));
      check_eq($sformatf("u%0d_count", i), g_c, k[i]);
    end
  endtask

  task automatic cycle(input logic r, input logic l, input logic [15:0] d, input logic e, input logic s);
    rst = r; load = l; data = d; en = e; ser = s;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic flush();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
  endtask

  logic [7:0]  pat8;
  logic [15:0] pat16;
  int          n_en;

  initial begin
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    check_eq("reset_ready", 32'(r0), 1);
    check_eq("reset_count", 32'(c0), 0);
    cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // 0x1E LSB first, serial_i=0, enable every cycle
    pat8 = 8'h1E;
    cycle(1'b0, 1'b1, 16'h001E, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      check_eq("t1_serial", 32'(s0), 32'(pat8[i]));
    end
    check_eq("t1_done", 32'(d0), 1);
    check_eq("t1_data", 32'(q0), 32'h00);
    check_eq("t1_count", 32'(c0), 8);
    flush();

    // 0x1E MSB first, serial_i 1,0,0,0,0,0,0,1
    cycle(1'b0, 1'b1, 16'h001E, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, (i == 0 || i == 7));
      check_eq("t2_serial", 32'(s1), 32'(pat8[7 - i]));
    end
    check_eq("t2_done", 32'(d1), 1);
    check_eq("t2_data", 32'(q1), 32'h81);
    flush();

    // 0xFF with enable gaps, serial_i 1 then 0s
    cycle(1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0);
    n_en = 0;
    for (int j = 0; j < 24 && n_en < 8; j++) begin
      cycle(1'b0, 1'b0, 16'h0, (j % 3 == 0), (n_en == 0));
      if (j % 3 == 0) n_en++;
      if (n_en < 8) check_eq("t3_no_early_done", 32'(d0), 0);
    end
    check_eq("t3_done", 32'(d0), 1);
    check_eq("t3_data", 32'(q0), 32'h01);
    flush();

    // 0xA5 with a load attempt mid-transfer that must be ignored
    pat8 = 8'hA5;
    cycle(1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, (i >= 3), 16'h0, 1'b1, 1'b0);
      check_eq("t4_serial", 32'(s0), 32'(pat8[i]));
      if (i < 7) check_eq("t4_ready_low", 32'(r0), 0);
    end
    check_eq("t4_done", 32'(d0), 1);
    flush();

    // reset after 4 shifts, then a clean transfer of 0x3C
    cycle(1'b0, 1'b1, 16'h003C, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b1);
    check_eq("t5_rst_ready", 32'(r0), 1);
    check_eq("t5_rst_done", 32'(d0), 0);
    check_eq("t5_rst_data", 32'(q0), 0);
    check_eq("t5_rst_serial", 32'(s0), 0);
    cycle(1'b0, 1'b1, 16'h003C, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    check_eq("t5_done", 32'(d0), 1);
    check_eq("t5_data", 32'(q0), 32'hFF);
    flush();

    // WIDTH=16: 0x8001 with serial_i held at 1
    pat16 = 16'h8001;
    cycle(1'b0, 1'b1, 16'h8001, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
      check_eq("t6_serial", 32'(s2), 32'(pat16[i]));
    end
    check_eq("t6_done", 32'(d2), 1);
    check_eq("t6_data", 32'(q2), 32'hFFFF);
    check_eq("t6_count", 32'(c2), 16);
    flush();

    // randomized traffic, model checks every output every cycle
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
            16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
